// File: rtl/score_link_pkg.sv
// score_link_pkg: constants shared by the score link transmitter on basys_1 and the receiver on basys_2
package score_link_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_BYTES = 4;
  localparam int B2_THIRD = 0;
  localparam int B2_FLAG = 1;
  localparam int B2_END = 2;
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    LOAD = 3'b010,
    SEND = 3'b100
  } seq_state_t;
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-byte 8N1 serializer, LSB first; done pulses in the last clock of the stop bit
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [8:0]    sh;
  logic          wrap;
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign done = active && wrap && bitn == 4'd9;
  assign tx   = active ? sh[0] : 1'b1;
  // Shift start+data out one bit per wrap, filling with ones so the stop bit falls out naturally;
  // a start in the final stop-bit clock reloads the next byte with no idle gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= 1'b0;
      cnt    <= '0;
      bitn   <= '0;
      sh     <= '1;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      bitn   <= '0;
      sh     <= {data, 1'b0};
    end else if (active) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        bitn   <= bitn + 4'd1;
        sh     <= {1'b1, sh[8:1]};
        active <= bitn != 4'd9;
      end
    end
  end
endmodule

// File: rtl/score_link_tx.sv
// score_link_tx: sends a 4-byte 8N1 frame of the judge outputs on every change; SCORE_LINK_HEARTBEAT_EN adds periodic resends
module score_link_tx
  import score_link_pkg::*;
#(
  parameter int CLK_FREQ = 65_000_000,
  parameter int BAUD     = 115_200
`ifdef SCORE_LINK_HEARTBEAT_EN
  , parameter int HEARTBEAT_CYCLES = 6_500_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_player1,
  input  logic [3:0] score_player2,
  input  logic       flag_point,
  input  logic       thirdtouched,
  input  logic       endgame,
  output logic       tx,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  seq_state_t  state, state_n;
  logic [10:0] snap, shadow;
  logic [7:0]  b1, b2, data;
  logic [2:0]  idx;
  logic        pending, first, start, done, last, changed, trig, hb_hit;
  assign snap    = {score_player1, score_player2, endgame, flag_point, thirdtouched};
  assign b1      = shadow[10:3];
  assign changed = snap != shadow;
  assign trig    = changed || pending || hb_hit;
  assign last    = idx == 3'(FRAME_BYTES);
  assign busy    = state != IDLE;
  assign data    = idx == 3'd0 ? SYNC_BYTE : idx == 3'd1 ? b1 : idx == 3'd2 ? b2 : b1 ^ b2;
  // Flag byte assembled from the shadow so the frame in flight never follows the live inputs
  always_comb begin
    b2         = '0;
    b2[B2_END]   = shadow[2];
    b2[B2_FLAG]  = shadow[1];
    b2[B2_THIRD] = shadow[0];
  end
`ifdef SCORE_LINK_HEARTBEAT_EN
  localparam int HW = $clog2(HEARTBEAT_CYCLES + 1);
  logic [HW-1:0] hb_cnt;
  assign hb_hit = hb_cnt == HW'(HEARTBEAT_CYCLES - 1);
  // Heartbeat period is measured from the start of the most recent frame
  always_ff @(posedge clk) begin
    if (!rst || (state == IDLE && trig) || hb_hit) hb_cnt <= '0;
    else hb_cnt <= hb_cnt + 1'b1;
  end
`else
  assign hb_hit = 1'b0;
`endif
  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // Next state and byte-start strobe: first byte kicks one cycle after LOAD, later bytes chain on done
  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: state_n = trig ? LOAD : IDLE;
      LOAD: state_n = SEND;
      SEND: begin
        start   = first || (done && !last);
        state_n = (done && last) ? IDLE : SEND;
      end
      default: state_n = IDLE;
    endcase
  end
  // Snapshot on frame start; any change or heartbeat while busy is remembered as one pending resend
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow  <= '0;
      pending <= 1'b0;
      idx     <= '0;
      first   <= 1'b0;
    end else begin
      first <= state == LOAD;
      if (state == IDLE && trig) begin
        shadow  <= snap;
        pending <= 1'b0;
      end else if (state != IDLE && (changed || hb_hit)) begin
        pending <= 1'b1;
      end
      if (state == LOAD) idx <= '0;
      else if (start) idx <= idx + 3'd1;
    end
  end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .tx   (tx),
    .done (done)
  );
endmodule

// File: tb/tb_score_link_tx.sv
// tb_score_link_tx: decodes the serial line and checks frames, latency, busy and reset behaviour at 10 clks/bit
module tb_score_link_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] in_v;
  logic        tx, busy;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [10:0] in;
    logic [7:0]  b1, b2, b3;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  score_link_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk          (clk),
    .rst          (rst),
    .score_player1(in_v[10:7]),
    .score_player2(in_v[6:3]),
    .flag_point   (in_v[1]),
    .thirdtouched (in_v[0]),
    .endgame      (in_v[2]),
    .tx           (tx),
    .busy         (busy)
  );

  function automatic logic [31:0] model_frame(input logic [10:0] v);
    logic [7:0] b1, b2;
    b1 = v[10:3];
    b2 = {5'b0, v[2:0]};
    return {b1 ^ b2, b2, b1, 8'hA5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a start bit, decodes 40 bits at mid-bit, checks frame, latency, busy and idle after
  task automatic expect_frame(input string name, input logic [31:0] ef, input int ew);
    int w;
    logic [39:0] bits;
    logic [31:0] f;
    bit framing, busy_all;
    w = 0;
    while (tx !== 1'b0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no start bit within %0d clks", name, w);
      return;
    end
    if (ew >= 0) chk({name, "_latency"}, w, ew);
    busy_all = 1'b1;
    for (int j = 0; j < 40; j++)
      for (int k = 0; k < 10; k++) begin
        if (k == 5) bits[j] = tx;
        busy_all &= (busy === 1'b1);
        @(negedge clk);
      end
    framing = 1'b1;
    for (int b = 0; b < 4; b++) begin
      framing &= (bits[10*b] === 1'b0) && (bits[10*b+9] === 1'b1);
      for (int i = 0; i < 8; i++) f[8*b+i] = bits[10*b+1+i];
    end
    chk({name, "_bytes"}, f, ef);
    chk({name, "_framing"}, 32'(framing), 32'd1);
    chk({name, "_busy_high"}, 32'(busy_all), 32'd1);
    chk({name, "_end_idle"}, {30'd0, busy, tx}, 32'd1);
  endtask

  task automatic quiet(input string name, input int n);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      ok &= (tx === 1'b1) && (busy === 1'b0);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  logic [10:0] nv;
  int          d, nchg;

  initial begin
    tbl[0] = '{{4'h3, 4'h1, 3'b100}, 8'h31, 8'h04, 8'h35};
    tbl[1] = '{{4'hF, 4'hF, 3'b111}, 8'hFF, 8'h07, 8'hF8};
    tbl[2] = '{{4'h0, 4'h0, 3'b001}, 8'h00, 8'h01, 8'h01};
    tbl[3] = '{{4'hA, 4'h5, 3'b010}, 8'hA5, 8'h02, 8'hA7};
    tbl[4] = '{{4'h0, 4'h9, 3'b000}, 8'h09, 8'h00, 8'h09};

    rst  = 1'b0;
    in_v = {4'h3, 4'h0, 3'b000};
    repeat (5) @(negedge clk);
    chk("reset_state", {30'd0, busy, tx}, 32'd1);
    rst = 1'b1;
    expect_frame("release", 32'h3000_30A5, 3);

    for (int i = 0; i < 5; i++) begin
      in_v = tbl[i].in;
      expect_frame($sformatf("vec%0d", i), {tbl[i].b3, tbl[i].b2, tbl[i].b1, 8'hA5}, 3);
    end

    in_v = {4'h3, 4'h1, 3'b000};
    fork
      expect_frame("inflight", 32'h3100_31A5, 3);
      begin
        repeat (100) @(negedge clk);
        in_v[10:7] = 4'h4;
        repeat (100) @(negedge clk);
        in_v[10:7] = 4'h5;
      end
    join
    expect_frame("followup", 32'h5100_51A5, -1);
    quiet("idle_2000", 2000);

    in_v = {4'h7, 4'h2, 3'b001};
    d = 0;
    while (tx !== 1'b0 && d < 60) begin
      @(negedge clk);
      d++;
    end
    chk("midreset_started", {31'd0, tx}, 32'd0);
    repeat (165) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_abort", {30'd0, busy, tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_frame("after_reset", model_frame(in_v), 3);
    quiet("after_reset_quiet", 50);

    for (int r = 0; r < 20; r++) begin
      nv = 11'($urandom);
      if (nv == in_v) nv ^= 11'h001;
      in_v = nv;
      nchg = $urandom_range(0, 3);
      fork
        expect_frame($sformatf("rand%0d", r), model_frame(nv), 3);
        for (int c = 0; c < nchg; c++) begin
          d = $urandom_range(20, 120);
          repeat (d) @(negedge clk);
          in_v = in_v ^ 11'($urandom_range(1, 2047));
        end
      join
      if (nchg > 0) expect_frame($sformatf("rand%0d_follow", r), model_frame(in_v), -1);
    end
    quiet("final_quiet", 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
